// File: rtl/mod_exp_engine.sv
// Modular exponentiation core: result = base^exponent mod modulus, LSB-first square-and-multiply.
// Define MOD_EXP_EARLY_EXIT_EN to stop after the exponent's top set bit (variable latency).
module mod_exp_engine #(
    parameter int WIDTH     = 128,
    parameter int EXP_WIDTH = 256
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     base,
    input  logic [EXP_WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0]     modulus,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [WIDTH-1:0]     result
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int KW = $clog2(EXP_WIDTH + 1);
    localparam logic [BW-1:0] BIT_TOP = BW'(WIDTH - 1);
    localparam logic [KW-1:0] K_LAST  = KW'(EXP_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_MUL,
        S_UPD,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [WIDTH-1:0]     r_base;
    logic [WIDTH-1:0]     r_mod;
    logic [EXP_WIDTH-1:0] r_exp;
    logic [WIDTH-1:0]     r_acc;
    logic [WIDTH-1:0]     r_sq;
    logic [WIDTH:0]       r_p;
    logic [WIDTH:0]       r_q;
    logic [BW-1:0]        r_bit;
    logic [KW-1:0]        r_k;
    logic                 r_bad;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_err;
    logic [WIDTH-1:0]     r_result;

    logic                 w_accept;
    logic                 w_bad;
    logic                 w_skip;
    logic                 w_last;
    logic [WIDTH:0]       w_p_next;
    logic [WIDTH:0]       w_q_next;

    // One MSB-first shift-add step; R<m keeps every sum within WIDTH+1 bits.
    function automatic logic [WIDTH:0] mm_step(
        input logic [WIDTH:0] r,
        input logic           b,
        input logic [WIDTH:0] mc,
        input logic [WIDTH:0] m
    );
        logic [WIDTH:0] t;
        t = {r[WIDTH-1:0], 1'b0};
        if (t >= m) t = t - m;
        if (b) begin
            t = t + mc;
            if (t >= m) t = t - m;
        end
        return t;
    endfunction

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_bad    = (r_mod[WIDTH-1:1] == '0) || (r_base >= r_mod);

`ifdef MOD_EXP_EARLY_EXIT_EN
    assign w_skip = (r_exp == '0);
    assign w_last = (r_k == K_LAST) || ((r_exp >> 1) == '0);
`else
    assign w_skip = 1'b0;
    assign w_last = (r_k == K_LAST);
`endif

    assign w_p_next = mm_step(r_p, r_acc[r_bit], {1'b0, r_sq}, {1'b0, r_mod});
    assign w_q_next = mm_step(r_q, r_sq[r_bit], {1'b0, r_sq}, {1'b0, r_mod});

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_next = S_CHECK;
            S_CHECK: w_next = (w_bad || w_skip) ? S_DONE : S_MUL;
            S_MUL:   if (r_bit == '0) w_next = S_UPD;
            S_UPD:   w_next = w_last ? S_DONE : S_MUL;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_base   <= '0;
            r_mod    <= '0;
            r_exp    <= '0;
            r_acc    <= '0;
            r_sq     <= '0;
            r_p      <= '0;
            r_q      <= '0;
            r_bit    <= '0;
            r_k      <= '0;
            r_bad    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_result <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_base   <= base;
                        r_mod    <= modulus;
                        r_exp    <= exponent;
                        r_busy   <= 1'b1;
                        r_err    <= 1'b0;
                        r_result <= '0;
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                S_CHECK: begin
                    r_bad <= w_bad;
                    r_acc <= WIDTH'(1);
                    r_sq  <= r_base;
                    r_p   <= '0;
                    r_q   <= '0;
                    r_bit <= BIT_TOP;
                    r_k   <= '0;
                end
                S_MUL: begin
                    r_p   <= w_p_next;
                    r_q   <= w_q_next;
                    r_bit <= r_bit - 1'b1;
                end
                S_UPD: begin
                    if (r_exp[0]) r_acc <= r_p[WIDTH-1:0];
                    r_sq  <= r_q[WIDTH-1:0];
                    r_exp <= r_exp >> 1;
                    r_k   <= r_k + 1'b1;
                    r_p   <= '0;
                    r_q   <= '0;
                    r_bit <= BIT_TOP;
                end
                S_DONE: begin
                    r_done   <= 1'b1;
                    r_err    <= r_bad;
                    r_result <= r_bad ? '0 : r_acc;
                end
                default: ;
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign err    = r_err;
    assign result = r_result;

endmodule
